// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose
//   Bit-serial adder sequencer built around one shared 1-bit full-adder slice.
//   The operands are accepted over a valid/ready handshake. One bit pair per
//   clock passes through the full adder, LSB first, and the carry is registered
//   between bits. The WIDTH-bit sum and the carry-out are returned over a second
//   valid/ready handshake. This is the minimum-area adder path for the
//   multi-bit ALU.
//
// Parameters
//   WIDTH      operand and sum width in bits, 2..32 (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   the a/b/cin operands are valid
//   in_ready   the block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum/cout are valid (DONE only)
//   out_ready  the consumer accepts the result
//   sum        a + b + cin, low WIDTH bits (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   busy       high in RUN or DONE
//   overflow   signed overflow; exists only when SERIAL_ADD_OVF_EN is defined
//
// Build option
//   SERIAL_ADD_OVF_EN : adds the overflow port and the logic that drives it.
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  // The single shared full-adder slice. It works on the current LSBs of the
  // shift registers and on the registered carry.
  logic fa_axb;
  logic fa_sum;
  logic fa_cout;
  assign fa_axb  = a_sh_reg[0] ^ b_sh_reg[0];
  assign fa_sum  = fa_axb ^ carry_reg;
  assign fa_cout = (a_sh_reg[0] & b_sh_reg[0]) | (fa_axb & carry_reg);

  logic last_bit;
  assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Each sum bit enters at the MSB. After WIDTH shifts, bit 0 has
          // reached position 0.
          sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          carry_reg <= fa_cout;
          if (last_bit) begin
            // The counter is held on the last bit so it never counts past WIDTH-1.
            cout_reg  <= fa_cout;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;

  // On the MSB step, carry_reg holds the carry into the MSB. Signed overflow
  // is that carry XOR the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (last_bit) begin
      ovf_reg <= carry_reg ^ fa_cout;
    end
  end

  assign overflow = ovf_reg;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH=8 instance
  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, s8;
  // WIDTH=4 instance
  logic       iv4, ir4, ov4, or4, cin4, cout4, busy4;
  logic [3:0] a4, b4, s4;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf4;
`endif

  int compared   = 0;
  int mismatched = 0;
  int hs4        = 0;
  int acc4       = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
    , .overflow(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(cout4), .busy(busy4)
`ifdef SERIAL_ADD_OVF_EN
    , .overflow(ovf4)
`endif
  );

  // Count the handshakes the 4-bit DUT makes on both sides.
  always @(posedge clk) begin
    if (rst_n && ov4 && or4) hs4 <= hs4 + 1;
    if (rst_n && iv4 && ir4) acc4 <= acc4 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: plain integer addition, WIDTH+1 bits wide.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Signed overflow: the operands have equal signs and the result sign differs.
  function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    r = ref8(x, y, c);
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // A single transaction on the 8-bit DUT: accept, check latency and result,
  // optionally stall in DONE (injecting an ignored in_valid), then handshake.
  task automatic add8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic c, input int stall, input bit inject);
    logic [8:0] exp;
    int lat;
    exp = ref8(x, y, c);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
    check({tag, "_in_ready"}, ir8, 1'b1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    // Scramble the operands after acceptance; the result must not change.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check({tag, "_busy"}, busy8, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ov8) begin lat = i; break; end
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_sum"}, s8, exp[7:0]);
    check({tag, "_cout"}, cout8, exp[8]);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, ovf8, ref_ovf8(x, y, c));
`endif
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (inject) begin iv8 = 1'b1; a8 = 8'h11; end
      check({tag, "_stall_valid"}, ov8, 1'b1);
      check({tag, "_stall_ready"}, ir8, 1'b0);
      check({tag, "_stall_sum"}, {cout8, s8}, exp);
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check({tag, "_post_valid"}, ov8, 1'b0);
    check({tag, "_post_ready"}, ir8, 1'b1);
    check({tag, "_held_sum"}, {cout8, s8}, exp);
    $display("add8 %s: %02h + %02h + %0d -> sum=%02h cout=%0d latency=%0d", tag, x, y, c, s8, cout8, lat);
  endtask

  initial begin
    logic saw;
    logic [4:0] e4;
    int lat;
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ir8, 1'b1);
    check("rst_out_valid", ov8, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {ir8, ov8, busy8, cout8, s8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    check("reset_state4", {ir4, ov4, busy4}, 3'b100);
`ifdef SERIAL_ADD_OVF_EN
    check("reset_ovf", ovf8, 1'b0);
`endif

    // Directed cases
    add8("t1_zero", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    add8("t2_ff01", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    add8("t2_7f01", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    add8("t3_a55a", 8'hA5, 8'h5A, 1'b1, 5, 1'b1);

    // Reset during the third RUN cycle of 12+34
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_abort_state", {ov8, ir8, busy8, cout8, s8}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) saw = 1'b1;
    end
    check("t4_no_pulse", saw, 1'b0);
    add8("t4_1234", 8'h12, 8'h34, 1'b0, 0, 1'b0);

    // Random operands with random stalls
    for (int i = 0; i < 16; i++)
      add8("rand", 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0);

    // WIDTH=4: every operand pair and both carry-in values
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          e4 = 5'(x) + 5'(y) + 5'(c);
          @(negedge clk);
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); iv4 = 1'b1; or4 = 1'($urandom);
          @(posedge clk); #1;
          iv4 = 1'b0;
          lat = 0;
          for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ov4) begin lat = i; break; end
            or4 = 1'($urandom);  // ignored outside DONE
          end
          check("w4_result", {ov4, lat[4:0], cout4, s4}, {1'b1, 5'd4, e4});
`ifdef SERIAL_ADD_OVF_EN
          check("w4_ovf", ovf4, (x[3] == y[3]) && (e4[3] != 1'(x >> 3)));
`endif
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            or4 = (k >= 3) ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
            if (!ov4) break;
          end
        end
      end
    end
    @(negedge clk);
    or4 = 1'b0;
    check("w4_out_handshakes", hs4, 512);
    check("w4_in_handshakes", acc4, 512);
    $display("w4 exhaustive: %0d accepted, %0d returned", acc4, hs4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
